// File: rtl/pulse_stretcher.sv
// Pulse stretcher: expands a one-cycle trigger into an o_pulse level that lasts
// i_length cycles. It can optionally retrigger and optionally enforce a low hold-off.
module pulse_stretcher #(
    parameter int WIDTH     = 8,
    parameter bit RETRIGGER = 1'b0,
    parameter int HOLDOFF   = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_trigger,
    input  logic [WIDTH-1:0] i_length,
    output logic             o_pulse,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_missed,
    output logic [1:0]       o_state
);

    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             missed_q, missed_d;

    logic len_nz;
    assign len_nz = (i_length != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            hold_q      <= '0;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            hold_q      <= hold_d;
            pulse_q     <= pulse_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            missed_q    <= missed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        hold_d      = hold_q;
        pulse_d     = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        missed_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_trigger) begin
                    if (len_nz) begin
                        state_d     = S_ACTIVE;
                        remaining_d = i_length;
                        pulse_d     = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        missed_d = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (i_trigger && RETRIGGER && len_nz) begin
                    // A reload on the final cycle wins over ending the pulse.
                    remaining_d = i_length;
                    pulse_d     = 1'b1;
                    busy_d      = 1'b1;
                end else begin
                    missed_d = i_trigger;
                    if (remaining_q == WIDTH'(1)) begin
                        remaining_d = '0;
                        done_d      = 1'b1;
                        if (HOLDOFF > 0) begin
                            state_d = S_HOLDOFF;
                            hold_d  = HW'(HOLDOFF);
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        remaining_d = remaining_q - WIDTH'(1);
                        pulse_d     = 1'b1;
                        busy_d      = 1'b1;
                    end
                end
            end
            S_HOLDOFF: begin
                missed_d = i_trigger;
                if (hold_q <= HW'(1)) begin
                    hold_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - HW'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_pulse  = pulse_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_missed = missed_q;
    assign o_state  = state_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Drives four differently parameterised pulse stretchers from one random stimulus stream.
// Expected outputs come from a timestamp model that tracks when each pulse and busy window ends.
module tb_pulse_stretcher;

    logic       clk;
    logic       rst;
    logic       trig;
    logic [7:0] len_r;

    logic pulse_w  [4];
    logic busy_w   [4];
    logic done_w   [4];
    logic missed_w [4];
    logic [1:0] state_w [4];

    // Per-instance configuration: width, retrigger, hold-off.
    int w_p    [4] = '{8, 8, 8, 4};
    int re_p   [4] = '{0, 1, 0, 1};
    int hold_p [4] = '{0, 0, 3, 2};

    int high_end [4];
    int busy_end [4];
    int cyc;
    int checks;
    int failures;

    pulse_stretcher #(.WIDTH(8), .RETRIGGER(1'b0), .HOLDOFF(0)) u0 (
        .i_clk(clk), .i_rst(rst), .i_trigger(trig), .i_length(len_r),
        .o_pulse(pulse_w[0]), .o_busy(busy_w[0]), .o_done(done_w[0]),
        .o_missed(missed_w[0]), .o_state(state_w[0]));
    pulse_stretcher #(.WIDTH(8), .RETRIGGER(1'b1), .HOLDOFF(0)) u1 (
        .i_clk(clk), .i_rst(rst), .i_trigger(trig), .i_length(len_r),
        .o_pulse(pulse_w[1]), .o_busy(busy_w[1]), .o_done(done_w[1]),
        .o_missed(missed_w[1]), .o_state(state_w[1]));
    pulse_stretcher #(.WIDTH(8), .RETRIGGER(1'b0), .HOLDOFF(3)) u2 (
        .i_clk(clk), .i_rst(rst), .i_trigger(trig), .i_length(len_r),
        .o_pulse(pulse_w[2]), .o_busy(busy_w[2]), .o_done(done_w[2]),
        .o_missed(missed_w[2]), .o_state(state_w[2]));
    pulse_stretcher #(.WIDTH(4), .RETRIGGER(1'b1), .HOLDOFF(2)) u3 (
        .i_clk(clk), .i_rst(rst), .i_trigger(trig), .i_length(len_r[3:0]),
        .o_pulse(pulse_w[3]), .o_busy(busy_w[3]), .o_done(done_w[3]),
        .o_missed(missed_w[3]), .o_state(state_w[3]));

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Model: the pulse is high for cycles before high_end; the block is busy before busy_end.
    task automatic model_step(input int k, input bit t, input int len_in, input bit r,
                              output bit ep, output bit eb, output bit ed, output bit em);
        int len;
        len = len_in % (1 << w_p[k]);
        em = 1'b0;
        if (r) begin
            high_end[k] = 0;
            busy_end[k] = 0;
        end else if (t) begin
            if (cyc >= busy_end[k]) begin
                if (len != 0) begin
                    high_end[k] = cyc + 1 + len;
                    busy_end[k] = high_end[k] + hold_p[k];
                end else begin
                    em = 1'b1;
                end
            end else if (cyc < high_end[k] && re_p[k] != 0 && len != 0) begin
                high_end[k] = cyc + 1 + len;
                busy_end[k] = high_end[k] + hold_p[k];
            end else begin
                em = 1'b1;
            end
        end
        ep = !r && (cyc + 1 < high_end[k]);
        eb = !r && (cyc + 1 < busy_end[k]);
        ed = !r && (cyc + 1 == high_end[k]);
    endtask

    // Driver: apply one cycle of inputs, let the edge pass, compare all instances.
    task automatic step(input bit t, input int len, input bit r);
        bit ep [4];
        bit eb [4];
        bit ed [4];
        bit em [4];
        trig  = t;
        len_r = len[7:0];
        rst   = r;
        for (int k = 0; k < 4; k++) model_step(k, t, len, r, ep[k], eb[k], ed[k], em[k]);
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("u%0d_pulse", k), 32'(pulse_w[k]), 32'(ep[k]));
            check($sformatf("u%0d_busy", k), 32'(busy_w[k]), 32'(eb[k]));
            check($sformatf("u%0d_done", k), 32'(done_w[k]), 32'(ed[k]));
            check($sformatf("u%0d_missed", k), 32'(missed_w[k]), 32'(em[k]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        trig     = 1'b0;
        len_r    = '0;
        rst      = 1'b1;
        for (int k = 0; k < 4; k++) begin
            high_end[k] = 0;
            busy_end[k] = 0;
        end
        @(posedge clk);
        #1;
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        // Basic pulse of 5
        step(1'b1, 5, 1'b0); idle(8);
        // Zero length, then back-to-back 3 / 2 with one low cycle
        step(1'b1, 0, 1'b0); idle(2);
        step(1'b1, 3, 1'b0); idle(3);
        step(1'b1, 2, 1'b0); idle(8);
        // Retrigger on the third high cycle
        step(1'b1, 4, 1'b0); idle(2);
        step(1'b1, 4, 1'b0); idle(10);
        // Hold-off: triggers during hold-off, then one right after busy falls
        step(1'b1, 2, 1'b0); idle(2);
        step(1'b1, 2, 1'b0); step(1'b1, 2, 1'b0); step(1'b1, 2, 1'b0);
        step(1'b1, 2, 1'b0); idle(8);
        // Reset on the fourth high cycle, then a normal pulse
        step(1'b1, 10, 1'b0); idle(3);
        step(1'b0, 0, 1'b1);
        step(1'b1, 2, 1'b0); idle(6);
        // Maximum length for the 4-bit instance
        step(1'b1, 15, 1'b0); idle(20);
        // Trigger coinciding with the last high cycle
        step(1'b1, 3, 1'b0); idle(2);
        step(1'b1, 3, 1'b0); idle(8);
        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bit t;
            bit r;
            int l;
            t = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) l = $urandom_range(0, 255);
            else l = $urandom_range(0, 6);
            step(t, l, r);
        end
        idle(300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts a single-cycle trigger strobe into a clean output level held high for a programmable number of clock cycles.
- This is the inverse of the edge-to-pulse one-shot: it expands a pulse into a level.
- Used for timer/port strobes, bus-cycle enables and indicator drive where a one-clock event must be held for a fixed time.
- Optional retrigger, and an optional enforced low hold-off between pulses.

Parameters:
- WIDTH, 8, width of the length input and of the internal remaining-count register.
- RETRIGGER, 0, if 1 a trigger during an active pulse reloads the length; if 0 it is rejected.
- HOLDOFF, 0, number of forced-low cycles after each pulse, during which triggers are rejected (0 = none).

Ports:
- i_clk  input  1  clock source.
- i_rst  input  1  synchronous, active-high reset.
- i_trigger  input  1  trigger strobe; every cycle sampled high is one trigger event.
- i_length  input  WIDTH  pulse length in cycles; sampled only on an accepted trigger.
- o_pulse  output  1  stretched output level (registered).
- o_busy  output  1  high while ACTIVE or HOLDOFF (registered).
- o_done  output  1  single-cycle strobe marking the end of a pulse (registered).
- o_missed  output  1  single-cycle strobe marking a rejected trigger (registered).

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high on i_clk.
- Reset state: IDLE, with remaining count 0, hold-off count 0, and o_pulse, o_busy, o_done, o_missed all 0.
- Reset mid-pulse: o_pulse drops at that edge and no o_done is issued.
- States: IDLE, ACTIVE, HOLDOFF.
- IDLE, i_trigger=1 and i_length!=0:
  - load remaining=i_length and go to ACTIVE.
  - o_pulse and o_busy go high at that edge (1-cycle latency from the trigger cycle).
- IDLE, i_trigger=1 and i_length=0: no pulse; o_missed=1 for the next cycle; stay in IDLE.
- ACTIVE, normal operation:
  - o_pulse is high for exactly L cycles, where L is the loaded length.
  - remaining decrements once per cycle.
  - At the edge where remaining==1 and no retrigger is accepted: o_pulse=0 and o_done=1 (one cycle).
  - Next state is HOLDOFF if HOLDOFF>0 (hold-off counter loaded with HOLDOFF), else IDLE.
- ACTIVE with i_trigger=1, RETRIGGER=1 and i_length!=0:
  - remaining reloads to i_length and the pulse continues with no low gap.
  - Total high time = cycles already high + new length.
  - This also applies on the final cycle (remaining==1).
  - No o_done for the superseded pulse.
- ACTIVE with i_trigger=1, RETRIGGER=0, or with i_length=0: o_missed=1 for one cycle; the pulse is unaffected.
- HOLDOFF:
  - o_pulse=0, o_busy=1; the counter decrements each cycle.
  - After HOLDOFF cycles, o_busy=0 and the state returns to IDLE.
  - Any trigger during HOLDOFF sets o_missed=1 for one cycle.
- Trigger acceptance boundary: a trigger is accepted only if the state is IDLE at the sampling edge.
  - With HOLDOFF=0, a trigger in the first low cycle after a pulse is accepted, giving exactly 1 low cycle between pulses.
  - A trigger coinciding with the o_done edge (last high cycle, RETRIGGER=0) is missed.
- A continuously high i_trigger counts as one trigger per cycle. Callers needing edge semantics place an edge detector upstream.
- Arithmetic: unsigned; maximum length 2^WIDTH-1 cycles. The hold-off counter is sized ceil(log2(HOLDOFF+1)) bits, minimum 1 bit.
- Outputs: o_done and o_missed are never high for more than one consecutive cycle per event. They may both be high in the same cycle (pulse ends while a trigger is rejected).

Test Plan:
- Basic, defaults (RETRIGGER=0, HOLDOFF=0):
  - Reset, then pulse i_trigger 1 cycle with i_length=5.
  - Expect: o_pulse high for exactly 5 cycles starting the cycle after the trigger; o_busy matches o_pulse.
  - Expect: o_done=1 in the first low cycle; o_missed stays 0.
- Zero length / back-to-back:
  - Trigger with i_length=0: o_missed=1 for 1 cycle, no pulse.
  - Trigger L=3, then trigger L=2 in the first low cycle after o_pulse falls: expect 3 high, 1 low, 2 high; o_done fires twice.
- Retrigger (RETRIGGER=1):
  - Trigger L=4; on the 3rd high cycle trigger again with L=4.
  - Expect: o_pulse continuously high for 7 cycles, a single o_done, no o_missed.
  - Repeat with RETRIGGER=0: 4 high cycles, o_missed=1 once.
- Hold-off (HOLDOFF=3):
  - Trigger L=2; expect 2 high cycles, then o_busy high 3 further cycles with o_pulse=0.
  - Triggers during those 3 cycles each produce o_missed.
  - A trigger on the cycle after o_busy falls produces a new pulse.
- Reset mid-operation:
  - Trigger L=10, assert i_rst on the 4th high cycle.
  - Expect: all outputs 0 from that edge, no o_done; after reset release a trigger with L=2 yields a normal 2-cycle pulse.
- Maximum length (WIDTH=4):
  - Trigger with i_length=15; expect exactly 15 high cycles with no wrap-around and o_done once.
